// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port among NUM_REQ write-back sources.
// The winning write is registered for one cycle; x0 targets are accepted but not written.
module rf_wb_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int CNT_WIDTH      = 16,
  localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]      req_data,
  input  logic                              stall,
  output logic                              wr_en,
  output logic [REG_ADDR_WIDTH-1:0]         addr_rd,
  output logic [REG_WIDTH-1:0]              data_rd,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic [CNT_WIDTH-1:0]              wb_count
);

  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]      data_q, data_d;
  logic [ID_WIDTH-1:0]       gid_q, gid_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [ID_WIDTH-1:0]       win_s;
  logic                      any_s;
  logic                      xfer_s;
  logic                      commit_s;
  logic [NUM_REQ-1:0]        ready_s;
  logic [REG_ADDR_WIDTH-1:0] win_addr_s;
  logic [REG_WIDTH-1:0]      win_data_s;

  // Rotating search: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_WIDTH:0] idx_raw;
    logic [ID_WIDTH:0] idx;
    win_s = {ID_WIDTH{1'b0}};
    any_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_raw = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
      idx     = (idx_raw >= NUM_REQ_W) ? (idx_raw - NUM_REQ_W) : idx_raw;
      if (!any_s && req_valid[idx[ID_WIDTH-1:0]]) begin
        any_s = 1'b1;
        win_s = idx[ID_WIDTH-1:0];
      end else begin
        any_s = any_s;
        win_s = win_s;
      end
    end
  end

  // Grant decode; reset and stall both suppress every grant.
  always_comb begin
    xfer_s  = any_s && !stall && reset_n;
    ready_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = xfer_s && (win_s == ID_WIDTH'(i));
    end
  end

  assign req_ready = ready_s;

  // Select the winner's address and data from the flattened request buses.
  always_comb begin
    win_addr_s = {REG_ADDR_WIDTH{1'b0}};
    win_data_s = {REG_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == ID_WIDTH'(i)) begin
        win_addr_s = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        win_data_s = req_data[i*REG_WIDTH +: REG_WIDTH];
      end else begin
        win_addr_s = win_addr_s;
        win_data_s = win_data_s;
      end
    end
    commit_s = xfer_s && (win_addr_s != {REG_ADDR_WIDTH{1'b0}});
  end

  // Next-state for the write port, pointer and performance counter.
  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    if (xfer_s) begin
      wr_en_d = commit_s;
      addr_d  = win_addr_s;
      data_d  = win_data_s;
      gid_d   = win_s;
      ptr_d   = (win_s == LAST_ID) ? {ID_WIDTH{1'b0}} : (win_s + ID_WIDTH'(1));
    end else begin
      wr_en_d = 1'b0;
      ptr_d   = ptr_q;
    end
    if (commit_s) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q <= 1'b0;
      addr_q  <= {REG_ADDR_WIDTH{1'b0}};
      data_q  <= {REG_WIDTH{1'b0}};
      gid_q   <= {ID_WIDTH{1'b0}};
      cnt_q   <= {CNT_WIDTH{1'b0}};
      ptr_q   <= {ID_WIDTH{1'b0}};
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign addr_rd  = addr_q;
  assign data_rd  = data_q;
  assign grant_id = gid_q;
  assign wb_count = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, a mid-operation reset sequence,
// and randomized traffic compared against a queue-free behavioural round-robin model.
module tb_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   addr_rd;
  logic [DW-1:0]   data_rd;
  logic [IW-1:0]   grant_id;
  logic [CW-1:0]   wb_count;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  rf_wb_arbiter #(
    .NUM_REQ(N), .REG_ADDR_WIDTH(AW), .REG_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .stall(stall), .wr_en(wr_en),
    .addr_rd(addr_rd), .data_rd(data_rd), .grant_id(grant_id), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [2:0]  valid;
    bit          stl;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  e_ready;
    bit          e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_gid;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, logic [2:0] v, bit s,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [2:0] er, bit ew, logic [4:0] ea,
                              logic [31:0] ed, logic [1:0] eg, logic [3:0] ec);
    vec_t r;
    r.rst = rst; r.valid = v; r.stl = s;
    r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.e_ready = er; r.e_wr = ew; r.e_addr = ea; r.e_data = ed; r.e_gid = eg; r.e_cnt = ec;
    return r;
  endfunction

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input bit ew, input logic [4:0] ea,
                               input logic [31:0] ed, input logic [1:0] eg, input logic [3:0] ec);
    chk({tag, ".wr_en"},    64'(wr_en),    64'(ew));
    chk({tag, ".addr_rd"},  64'(addr_rd),  64'(ea));
    chk({tag, ".data_rd"},  64'(data_rd),  64'(ed));
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(eg));
    chk({tag, ".wb_count"}, 64'(wb_count), 64'(ec));
  endtask

  // Behavioural model state for the randomized phase
  bit          pend[N];
  logic [4:0]  pa[N];
  logic [31:0] pd[N];
  int          m_ptr, m_gid, m_cnt;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC, 32'hB, 32'hA};
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req_ready", 64'(req_ready), 64'd0);
    check_outputs("reset", 1'b0, 5'd0, 32'd0, 2'd0, 4'd0);
    reset_n   = 1'b1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;

    tbl[0]  = mk(1'b1, 3'b001, 1'b0, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                 3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 4'd1);
    tbl[1]  = mk(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 4'd1);
    tbl[2]  = mk(1'b1, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0, 4'd1);
    tbl[3]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1, 4'd2);
    tbl[4]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2, 4'd3);
    tbl[5]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0, 4'd4);
    tbl[6]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b010, 1'b1, 5'd2, 32'hA1, 2'd1, 4'd5);
    tbl[7]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2, 4'd6);
    tbl[8]  = mk(1'b0, 3'b010, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h55, 32'h0,
                 3'b010, 1'b0, 5'd0, 32'h55, 2'd1, 4'd6);
    tbl[9]  = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b100, 1'b1, 5'd3, 32'hA2, 2'd2, 4'd7);
    tbl[10] = mk(1'b0, 3'b111, 1'b1, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b000, 1'b0, 5'd3, 32'hA2, 2'd2, 4'd7);
    tbl[11] = mk(1'b0, 3'b111, 1'b1, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b000, 1'b0, 5'd3, 32'hA2, 2'd2, 4'd7);
    tbl[12] = mk(1'b0, 3'b111, 1'b1, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b000, 1'b0, 5'd3, 32'hA2, 2'd2, 4'd7);
    tbl[13] = mk(1'b0, 3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2,
                 3'b001, 1'b1, 5'd1, 32'hA0, 2'd0, 4'd8);
    tbl[14] = mk(1'b1, 3'b101, 1'b0, 5'd7, 5'd0, 5'd7, 32'h11, 32'h0, 32'h22,
                 3'b001, 1'b1, 5'd7, 32'h11, 2'd0, 4'd1);
    tbl[15] = mk(1'b0, 3'b100, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h22,
                 3'b100, 1'b1, 5'd7, 32'h22, 2'd2, 4'd2);
    tbl[16] = mk(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                 3'b000, 1'b0, 5'd7, 32'h22, 2'd2, 4'd2);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) pulse_reset();
      req_valid = tbl[i].valid;
      stall     = tbl[i].stl;
      req_addr  = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
      req_data  = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("tbl%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      check_outputs($sformatf("tbl%0d", i), tbl[i].e_wr, tbl[i].e_addr,
                    tbl[i].e_data, tbl[i].e_gid, tbl[i].e_cnt);
    end

    // Reset right after a handshake discards the write and rewinds the pointer
    stall = 1'b0;
    pulse_reset();
    req_valid = 3'b111;
    req_addr  = {5'd11, 5'd10, 5'd9};
    req_data  = {32'h3, 32'h2, 32'h1};
    #1;
    chk("midrst.ready0", 64'(req_ready), 64'(3'b001));
    @(posedge clk);
    #1;
    chk("midrst.wr_before", 64'(wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst.wr_en", 64'(wr_en), 64'd0);
    chk("midrst.wb_count", 64'(wb_count), 64'd0);
    chk("midrst.ready_in_reset", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("midrst.ready_after", 64'(req_ready), 64'(3'b001));
    @(posedge clk);
    #1;
    check_outputs("midrst.after", 1'b1, 5'd9, 32'h1, 2'd0, 4'd1);

    // Randomized traffic against the behavioural model
    pulse_reset();
    m_ptr = 0; m_gid = 0; m_cnt = 0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = 5'd0; pd[i] = 32'd0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      logic [2:0] exp_ready;
      bit s;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(9, 0) < 6) begin
          pend[i] = 1'b1;
          pa[i]   = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
          pd[i]   = $urandom;
        end
        req_valid[i]         = pend[i];
        req_addr[i*AW +: AW] = pend[i] ? pa[i] : 5'($urandom_range(31, 0));
        req_data[i*DW +: DW] = pend[i] ? pd[i] : $urandom;
      end
      s = ($urandom_range(4, 0) == 0);
      stall = s;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
      exp_ready = (!s && g >= 0) ? 3'(1 << g) : 3'b000;
      chk($sformatf("rnd%0d.req_ready", cyc), 64'(req_ready), 64'(exp_ready));
      @(posedge clk);
      #1;
      if (!s && g >= 0) begin
        m_addr = pa[g];
        m_data = pd[g];
        m_gid  = g;
        m_wr   = (pa[g] != 5'd0);
        if (m_wr) m_cnt = (m_cnt + 1) % 16;
        m_ptr   = (g + 1) % N;
        pend[g] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      check_outputs($sformatf("rnd%0d", cyc), m_wr, m_addr, m_data, 2'(m_gid), 4'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
